// File: rtl/mirfak_dbus_bridge_if.sv
// Data-bus bridge interface: the master-facing dwbs port and the shared
// two-slave port. The bridge uses the slave modport; the environment that
// drives the master request and plays both slaves uses the master modport.
interface mirfak_dbus_bridge_if;
  logic [31:0] dwbs_addr_i;
  logic [31:0] dwbs_dat_i;
  logic [3:0]  dwbs_sel_i;
  logic        dwbs_cyc_i;
  logic        dwbs_stb_i;
  logic        dwbs_we_i;
  logic [31:0] dwbs_dat_o;
  logic        dwbs_ack_o;
  logic        dwbs_err_o;
  logic [31:0] slv_addr_o;
  logic [31:0] slv_dat_o;
  logic [3:0]  slv_sel_o;
  logic        slv_we_o;
  logic [1:0]  slv_cyc_o;
  logic [1:0]  slv_stb_o;
  logic [63:0] slv_dat_i;
  logic [1:0]  slv_ack_i;
  logic [1:0]  slv_err_i;

  modport slave (
    input  dwbs_addr_i, dwbs_dat_i, dwbs_sel_i, dwbs_cyc_i, dwbs_stb_i, dwbs_we_i,
    output dwbs_dat_o, dwbs_ack_o, dwbs_err_o,
    output slv_addr_o, slv_dat_o, slv_sel_o, slv_we_o, slv_cyc_o, slv_stb_o,
    input  slv_dat_i, slv_ack_i, slv_err_i
  );

  modport master (
    output dwbs_addr_i, dwbs_dat_i, dwbs_sel_i, dwbs_cyc_i, dwbs_stb_i, dwbs_we_i,
    input  dwbs_dat_o, dwbs_ack_o, dwbs_err_o,
    input  slv_addr_o, slv_dat_o, slv_sel_o, slv_we_o, slv_cyc_o, slv_stb_o,
    output slv_dat_i, slv_ack_i, slv_err_i
  );
endinterface

// File: rtl/mirfak_dbus_bridge.sv
// Single-master to two-slave data-bus bridge. A request is decoded against
// the memory and IO windows (memory wins on overlap), forwarded with
// registered address/data, and answered with a one-cycle ack or err pulse.
// A silent slave is cut off after TIMEOUT strobe cycles.
module mirfak_dbus_bridge #(
  parameter logic [31:0] MEM_BASE = 32'h0000_0000,
  parameter logic [31:0] MEM_MASK = 32'hF000_0000,
  parameter logic [31:0] IO_BASE  = 32'h8000_0000,
  parameter logic [31:0] IO_MASK  = 32'hF000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  mirfak_dbus_bridge_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [7:0]  cnt_r, cnt_s;
  logic        sel_r, sel_s;          // 0 = memory, 1 = IO
  logic        ack_r, ack_s;
  logic        err_r, err_s;
  logic [31:0] dat_r, dat_s;
  logic [31:0] addr_r, addr_s;
  logic [31:0] wdat_r, wdat_s;
  logic [3:0]  be_r, be_s;
  logic        we_r, we_s;
  logic [1:0]  req_r, req_s;          // drives both slv_cyc_o and slv_stb_o

  logic        hit_mem_s;
  logic        hit_io_s;
  logic        sel_ack_s;
  logic        sel_err_s;
  logic [31:0] sel_dat_s;

  assign hit_mem_s = (bus.dwbs_addr_i & MEM_MASK) == MEM_BASE;
  assign hit_io_s  = (bus.dwbs_addr_i & IO_MASK) == IO_BASE;
  assign sel_ack_s = bus.slv_ack_i[sel_r];
  assign sel_err_s = bus.slv_err_i[sel_r];
  assign sel_dat_s = sel_r ? bus.slv_dat_i[63:32] : bus.slv_dat_i[31:0];

  // Next-state and next-output logic; every register holds unless changed,
  // while ack/err default low so they can only ever be single-cycle pulses.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    sel_s   = sel_r;
    ack_s   = 1'b0;
    err_s   = 1'b0;
    dat_s   = dat_r;
    addr_s  = addr_r;
    wdat_s  = wdat_r;
    be_s    = be_r;
    we_s    = we_r;
    req_s   = req_r;
    case (state_r)
      IDLE: begin
        if (bus.dwbs_cyc_i && bus.dwbs_stb_i) begin
          addr_s = bus.dwbs_addr_i;
          wdat_s = bus.dwbs_dat_i;
          be_s   = bus.dwbs_sel_i;
          we_s   = bus.dwbs_we_i;
          cnt_s  = 8'd0;
          if (hit_mem_s) begin
            sel_s   = 1'b0;
            req_s   = 2'b01;
            state_s = REQ;
          end else if (hit_io_s) begin
            sel_s   = 1'b1;
            req_s   = 2'b10;
            state_s = REQ;
          end else begin
            err_s   = 1'b1;
            dat_s   = 32'h0000_0000;
            state_s = RESP;
          end
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (!bus.dwbs_cyc_i) begin
          // master walked away: release the slave silently
          req_s   = 2'b00;
          state_s = IDLE;
        end else if (sel_err_s) begin
          // err beats a simultaneous ack
          req_s   = 2'b00;
          err_s   = 1'b1;
          dat_s   = 32'h0000_0000;
          state_s = RESP;
        end else if (sel_ack_s) begin
          // ack beats a timeout falling in the same cycle
          req_s   = 2'b00;
          ack_s   = 1'b1;
          dat_s   = sel_dat_s;
          state_s = RESP;
        end else if (cnt_r == 8'(TIMEOUT - 1)) begin
          req_s   = 2'b00;
          err_s   = 1'b1;
          dat_s   = 32'h0000_0000;
          state_s = RESP;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        req_s   = 2'b00;
        state_s = IDLE;
      end
    endcase
  end

  // State, counter and registered outputs; reset clears everything at once.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
      sel_r   <= 1'b0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      dat_r   <= 32'h0000_0000;
      addr_r  <= 32'h0000_0000;
      wdat_r  <= 32'h0000_0000;
      be_r    <= 4'h0;
      we_r    <= 1'b0;
      req_r   <= 2'b00;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      sel_r   <= sel_s;
      ack_r   <= ack_s;
      err_r   <= err_s;
      dat_r   <= dat_s;
      addr_r  <= addr_s;
      wdat_r  <= wdat_s;
      be_r    <= be_s;
      we_r    <= we_s;
      req_r   <= req_s;
    end
  end

  assign bus.dwbs_dat_o = dat_r;
  assign bus.dwbs_ack_o = ack_r;
  assign bus.dwbs_err_o = err_r;
  assign bus.slv_addr_o = addr_r;
  assign bus.slv_dat_o  = wdat_r;
  assign bus.slv_sel_o  = be_r;
  assign bus.slv_we_o   = we_r;
  assign bus.slv_cyc_o  = req_r;
  assign bus.slv_stb_o  = req_r;

endmodule
